// File: rtl/regfile_wb.sv
// regfile_wb: architectural register file and writeback commit unit for the
// 16-bit THCO-MIPS core. Holds R0-R7, SP, IH, RA and T, decodes the commit
// destination from the retiring instruction word, forwards same-cycle writes
// to both read ports and counts retired bundles.
module regfile_wb #(
  parameter logic [15:0] SP_INIT = 16'h0000,
  parameter int          CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       rd_a_idx,
  input  logic [3:0]       rd_b_idx,
  output logic [15:0]      rd_a_data,
  output logic [15:0]      rd_b_data,
  input  logic             wb_valid,
  input  logic [15:0]      wb_instr,
  input  logic [15:0]      wb_res,
  input  logic             wb_t,
  input  logic             wb_t_wr_n,
  input  logic [15:0]      wb_mem_data,
  input  logic [15:0]      wb_link,
  output logic             t_out,
  output logic [15:0]      sp_out,
  output logic [15:0]      ih_out,
  output logic [15:0]      ra_out,
  output logic [3:0]       wb_dest,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] IDX_SP   = 4'd8;
  localparam logic [3:0] IDX_IH   = 4'd9;
  localparam logic [3:0] IDX_RA   = 4'd10;
  localparam logic [3:0] IDX_T    = 4'd11;
  localparam logic [3:0] IDX_NONE = 4'hF;

  logic [15:0]      gpr [0:7];
  logic [15:0]      sp_q, ih_q, ra_q;
  logic             t_q;
  logic [CNT_W-1:0] retired_q;

  logic [4:0]  op;
  logic [4:0]  funct;
  logic [3:0]  rx, ry, rz;
  logic [3:0]  dest;
  logic [15:0] wdata;
  logic        commit;
  logic        dest_ok;
  logic [15:0] view [0:15];
  logic        unused_instr_bit;

  assign op    = wb_instr[15:11];
  assign funct = wb_instr[4:0];
  assign rx    = {1'b0, wb_instr[10:8]};
  assign ry    = {1'b0, wb_instr[7:5]};
  assign rz    = {1'b0, wb_instr[4:2]};
  assign unused_instr_bit = wb_instr[1];

  // A commit only happens outside reset, so reads during reset never see forwarded data
  assign commit  = wb_valid & rst;
  assign dest_ok = (dest != IDX_NONE);

  // Decode the destination register and pick which bus supplies its data
  always_comb begin
    dest  = IDX_NONE;
    wdata = wb_res;
    case (op)
      5'b00000, 5'b00110, 5'b01001, 5'b01101, 5'b01111: dest = rx;
      5'b01000: dest = ry;
      5'b01100: begin
        if (wb_instr[10:8] == 3'b011 || wb_instr[10:8] == 3'b100) dest = IDX_SP;
      end
      5'b10010: begin
        dest  = rx;
        wdata = wb_mem_data;
      end
      5'b10011: begin
        dest  = ry;
        wdata = wb_mem_data;
      end
      5'b11100: dest = rz;
      5'b11101: begin
        case (funct)
          5'b00000: begin
            if (wb_instr[7:5] == 3'b010) begin
              dest = rx;
            end else if (wb_instr[7:5] == 3'b110) begin
              dest  = IDX_RA;
              wdata = wb_link;
            end
          end
          5'b00100, 5'b00110, 5'b00111: dest = ry;
          5'b01011, 5'b01100, 5'b01101, 5'b01110, 5'b01111: dest = rx;
          default: dest = IDX_NONE;
        endcase
      end
      5'b11110: dest = wb_instr[0] ? IDX_IH : rx;
      default: dest = IDX_NONE;
    endcase
  end

  assign wb_dest = dest;

  // Commit the decoded write, the independent T write and the retire count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) gpr[i] <= 16'h0000;
      sp_q      <= SP_INIT;
      ih_q      <= 16'h0000;
      ra_q      <= 16'h0000;
      t_q       <= 1'b0;
      retired_q <= '0;
    end else if (wb_valid) begin
      if (dest_ok) begin
        if (!dest[3]) gpr[dest[2:0]] <= wdata;
        else if (dest == IDX_SP) sp_q <= wdata;
        else if (dest == IDX_IH) ih_q <= wdata;
        else if (dest == IDX_RA) ra_q <= wdata;
      end
      if (!wb_t_wr_n) t_q <= wb_t;
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Flatten the stored state into the read-index space; reserved slots read zero
  always_comb begin
    for (int i = 0; i < 16; i++) view[i] = 16'h0000;
    for (int i = 0; i < 8; i++) view[i] = gpr[i];
    view[IDX_SP] = sp_q;
    view[IDX_IH] = ih_q;
    view[IDX_RA] = ra_q;
    view[IDX_T]  = {15'b0, t_q};
  end

  // Port A: stored value, overridden by a same-cycle register or T write
  always_comb begin
    rd_a_data = view[rd_a_idx];
    if (commit && dest_ok && rd_a_idx == dest) rd_a_data = wdata;
    if (commit && !wb_t_wr_n && rd_a_idx == IDX_T) rd_a_data = {15'b0, wb_t};
  end

  // Port B: same forwarding rules as port A
  always_comb begin
    rd_b_data = view[rd_b_idx];
    if (commit && dest_ok && rd_b_idx == dest) rd_b_data = wdata;
    if (commit && !wb_t_wr_n && rd_b_idx == IDX_T) rd_b_data = {15'b0, wb_t};
  end

  assign t_out   = t_q;
  assign sp_out  = sp_q;
  assign ih_out  = ih_q;
  assign ra_out  = ra_q;
  assign retired = retired_q;

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- Architectural register file and writeback commit unit for the 16-bit THCO-MIPS core.
- Sits at the opposite end of the execute datapath. It supplies the rs/rm operand values that feed the ALU, and commits the ALU result (res), the T flag (t), or load data back into state.
- Holds R0–R7, SP, IH, RA and T. Decodes the destination from the committed instruction word, bypasses same-cycle writes to the read ports, and counts retired instructions.

Parameters:
- SP_INIT, 16'h0000, reset value of SP.
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  commit clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-low.
- rd_a_idx  in  4  read port A index: 0–7 R0–R7, 8 SP, 9 IH, 10 RA, 11 T, 12–15 reserved.
- rd_b_idx  in  4  read port B index, same encoding.
- rd_a_data  out  16  port A value (combinational, bypassed).
- rd_b_data  out  16  port B value (combinational, bypassed).
- wb_valid  in  1  commit strobe for current wb_* bundle.
- wb_instr  in  16  instruction word being committed.
- wb_res  in  16  ALU result.
- wb_t  in  1  ALU T result.
- wb_t_wr_n  in  1  active-low T write enable from ALU.
- wb_mem_data  in  16  load data for lw/lw_sp.
- wb_link  in  16  link value for jalr (PC+1 computed upstream).
- t_out  out  1  current T bit.
- sp_out, ih_out, ra_out  out  16 each  direct architectural views.
- wb_dest  out  4  decoded destination of current bundle; 4'hF = none (combinational).
- retired  out  CNT_W  count of committed bundles.

Behaviour:
- Reset (rst=0, async): R0–R7=0, IH=0, RA=0, T=0, SP=SP_INIT, retired=0. Reads during reset return reset values. Deassertion is synchronous to the next posedge; no commit occurs on an edge while rst=0.
- Destination decode from op = wb_instr[15:11]; rx=[10:8], ry=[7:5], rz=[4:2]:
  - 00000 addsp3, 00110 sll/srl/sra, 01001 addiu, 01101 li, 01111 move -> rx.
  - 01000 addiu3 -> ry.
  - 01100: [10:8]=011 addsp or 100 mtsp -> SP; others none.
  - 10010 lw_sp -> rx; 10011 lw -> ry; both take data from wb_mem_data, not wb_res.
  - 11100 addu/subu -> rz.
  - 11101:
    - funct[4:0]=00000: [7:5]=010 mfpc -> rx; 110 jalr -> RA with data wb_link; 000/001 none.
    - 00100/00110/00111 sllv/srlv/srav -> ry.
    - 01011 neg, 01100 and, 01101 or, 01110 xor, 01111 not -> rx.
    - 00010/00011/01010 (slt/sltu/cmp) -> none.
    - Other funct values -> none.
  - 11110: [0]=0 mfih -> rx; [0]=1 mtih -> IH.
  - All other opcodes (b, beqz, bnez, nop, sw, sw_sp, int, slti, sltui, cmpi) -> none.
- Commit at posedge when wb_valid=1:
  - Decoded destination gets its data.
  - Independently, T <= wb_t if wb_t_wr_n=0, regardless of opcode.
  - retired increments by 1, wrapping modulo 2^CNT_W.
  - wb_valid=0: no state changes; wb_dest still reflects decode.
- Read ports: index 11 returns {15'b0,T}; 12–15 return 16'h0000.
- Bypass rules (same cycle, wb_valid=1):
  - If rd_x_idx equals the decoded destination, rd_x_data returns the commit data, not the stored value.
  - If rd_x_idx=11 and wb_t_wr_n=0, returns {15'b0,wb_t}.
  - Both ports may bypass the same write simultaneously.
- Single write per register per cycle. A GPR/SP/IH/RA write and a T write in the same bundle both take effect.
- Latency: commit visible in stored state one posedge after wb_valid; visible on read ports in the same cycle via bypass.

Test Plan:
- Reset: hold rst=0 with SP_INIT=16'hBF00, then release -> all rd_*=0 except idx 8 = 16'hBF00; t_out=0; retired=0.
- li R3,0x5A: wb_instr=16'h6B5A, wb_res=16'h005A, wb_valid=1, rd_a_idx=3 -> rd_a_data=16'h005A in the same cycle (bypass); stored 16'h005A after posedge; wb_dest=3; retired=1.
- lw R2 (ry=2) with wb_res=16'h1234, wb_mem_data=16'hBEEF -> R2=16'hBEEF; wb_res ignored.
- cmp with wb_t=1, wb_t_wr_n=0 -> T=1, wb_dest=4'hF, no GPR changes. Repeat with wb_t_wr_n=1 -> T unchanged.
- jalr (funct 00000, [7:5]=110) with wb_link=16'h0042 -> RA=16'h0042. mtih with wb_res=16'h8001 -> IH=16'h8001. addsp with wb_res=16'hBEFF -> SP=16'hBEFF.
- Mid-commit reset: assert rst=0 with wb_valid=1 before the edge -> no write; all state at reset values. Also drive 2^16 commits with CNT_W=16 -> retired wraps 16'hFFFF -> 16'h0000.
